// File: rtl/shift_row_rx_pkg.sv
// rtl/shift_row_rx_pkg.sv - shared FSM encodings, synchronizer depth and transmitter clock-generator constants
package shift_row_rx_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        DONE     = 2'd2,
        WAIT_GAP = 2'd3
    } rx_state_t;

    // Transmitter side: sclk phase and how many clk_in cycles each phase lasts.
    typedef enum logic {
        SCLK_LOW  = 1'b0,
        SCLK_HIGH = 1'b1
    } sclk_gen_state_t;

    localparam int SCLK_HALF_CYCLES = 2;

endpackage

// File: rtl/shift_row_rx_sync_edge_det.sv
// rtl/shift_row_rx_sync_edge_det.sv - multi-flop synchronizer with rising-edge detect
module sync_edge_det
    import shift_row_rx_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic sig,
    output logic sig_sync,
    output logic rise
);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], sig};
        prev_d = sync_q[SYNC_DEPTH-1];
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sig_sync = sync_q[SYNC_DEPTH-1];
    assign rise     = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/shift_row_rx.sv
// rtl/shift_row_rx.sv - deserialises sclk/sdata bursts into fixed-width rows with frame and overrun flags
module shift_row_rx
    import shift_row_rx_pkg::*;
#(
    parameter int WIDTH      = 150,
    parameter int WIDTH_BITS = 8,
    parameter int GAP        = 16,
    parameter int GAP_BITS   = 5
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] row_data,
    output logic             row_valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = WIDTH_BITS + 2;
    localparam logic [CW-1:0]       CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]       CNT_MAX  = '1;
    localparam logic [GAP_BITS-1:0] GAP_END  = GAP_BITS'(GAP);

    logic sclk_sync_unused, sclk_rise;
    logic sdata_sync, sdata_rise_unused;

    sync_edge_det u_sclk_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .sig      (sclk),
        .sig_sync (sclk_sync_unused),
        .rise     (sclk_rise)
    );

    sync_edge_det u_sdata_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .sig      (sdata),
        .sig_sync (sdata_sync),
        .rise     (sdata_rise_unused)
    );

    rx_state_t           state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [GAP_BITS-1:0] gap_q, gap_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [WIDTH-1:0]    row_data_q, row_data_d;
    logic                row_valid_q, row_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic [1:0]          arm_q, arm_d;

    logic                edge_det;
    logic [WIDTH:0]      shift_ext;
    logic [CW-1:0]       count_inc;
    logic [GAP_BITS-1:0] gap_inc;

    // A high sclk at reset release looks like a rising edge; ignore the first three cycles.
    assign edge_det  = sclk_rise & (arm_q == 2'd3);
    assign shift_ext = {shreg_q, sdata_sync};
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign gap_inc   = (gap_q >= GAP_END) ? GAP_END : gap_q + 1'b1;
    assign arm_d     = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            gap_q       <= '0;
            shreg_q     <= '0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            arm_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            shreg_q     <= shreg_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            arm_q       <= arm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (edge_det) state_d = (CNT_FULL == CW'(1)) ? DONE : SHIFT;
            SHIFT: begin
                if (edge_det) begin
                    if (count_inc == CNT_FULL) state_d = DONE;
                end else if (gap_inc == GAP_END) begin
                    state_d = IDLE;
                end
            end
            DONE:     state_d = WAIT_GAP;
            WAIT_GAP: if (!edge_det && gap_inc == GAP_END) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        gap_d       = gap_q;
        shreg_d     = shreg_q;
        row_data_d  = row_data_q;
        row_valid_d = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    shreg_d = shift_ext[WIDTH-1:0];
                    count_d = CW'(1);
                    gap_d   = '0;
                end
            end
            SHIFT: begin
                if (edge_det) begin
                    shreg_d = shift_ext[WIDTH-1:0];
                    count_d = count_inc;
                    gap_d   = '0;
                end else if (gap_inc == GAP_END) begin
                    frame_err_d = 1'b1;
                    count_d     = '0;
                    gap_d       = '0;
                end else begin
                    gap_d = gap_inc;
                end
            end
            DONE: begin
                row_data_d  = shreg_q;
                row_valid_d = 1'b1;
                gap_d       = gap_inc;
            end
            WAIT_GAP: begin
                if (edge_det) begin
                    overrun_d = 1'b1;
                    gap_d     = '0;
                end else if (gap_inc == GAP_END) begin
                    count_d = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_inc;
                end
            end
            default: begin
                count_d = '0;
                gap_d   = '0;
            end
        endcase
    end

    assign row_data  = row_data_q;
    assign row_valid = row_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_shift_row_rx.sv
// tb/tb_shift_row_rx.sv - directed bursts against a row-level reference model
module tb_shift_row_rx;
    import shift_row_rx_pkg::*;

    localparam int W = 8;
    localparam int G = 6;

    logic         clk_in = 1'b0;
    logic         reset  = 1'b1;
    logic         sclk   = 1'b0;
    logic         sdata  = 1'b0;
    logic [W-1:0] row_data;
    logic         row_valid, frame_err, overrun;

    shift_row_rx #(.WIDTH(W), .WIDTH_BITS(4), .GAP(G), .GAP_BITS(3)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sclk      (sclk),
        .sdata     (sdata),
        .row_data  (row_data),
        .row_valid (row_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_err = 0, n_ovr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pin samples -> delayed edge events -> row assembly.
    bit           p1, p2, p3, d1, d2;
    int           rel;
    bit           armed, ev, dbit;
    logic [W-1:0] col;
    int           nbits, quiet;
    bit           pending, full;
    logic [W-1:0] exp_row;
    bit           exp_valid, exp_err, exp_ovr;

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            {p1, p2, p3, d1, d2} = '0;
            rel = 0; col = '0; nbits = 0; quiet = 0;
            pending = 0; full = 0; exp_row = '0;
            exp_valid = 0; exp_err = 0; exp_ovr = 0;
        end else begin
            armed = (rel >= 3);
            if (rel < 3) rel++;
            ev   = armed && p2 && !p3;
            dbit = d2;
            p3 = p2; p2 = p1; p1 = sclk;
            d2 = d1; d1 = sdata;
            exp_valid = 0; exp_err = 0; exp_ovr = 0;
            if (pending) begin
                exp_row   = col;
                exp_valid = 1;
                pending   = 0;
                full      = 1;
                quiet++;
            end else if (ev) begin
                quiet = 0;
                if (full) exp_ovr = 1;
                else begin
                    col = {col[W-2:0], dbit};
                    nbits++;
                    if (nbits == W) pending = 1;
                end
            end else begin
                quiet++;
                if (full && quiet >= G) begin
                    full = 0; nbits = 0; quiet = 0;
                end else if (!full && nbits > 0 && quiet >= G) begin
                    exp_err = 1; nbits = 0; quiet = 0;
                end
            end
        end
    end

    always @(posedge clk_in) begin
        #1;
        if (!reset) begin
            check("row_data", row_data, exp_row);
            check("row_valid", row_valid, exp_valid);
            check("frame_err", frame_err, exp_err);
            check("overrun", overrun, exp_ovr);
            check("pulse_exclusive", (32'(row_valid) + 32'(frame_err) + 32'(overrun)) <= 1, 1);
            if (row_valid) n_valid++;
            if (frame_err) n_err++;
            if (overrun)   n_ovr++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        sclk  = 1'b1;
        repeat (SCLK_HALF_CYCLES) @(negedge clk_in);
        sclk  = 1'b0;
        repeat (SCLK_HALF_CYCLES) @(negedge clk_in);
    endtask

    task automatic send_bits(input logic [15:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    int v0, e0, o0;

    task automatic mark();
        v0 = n_valid; e0 = n_err; o0 = n_ovr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk_in);
        repeat (3) @(negedge clk_in);
        check("reset_row_data", row_data, 0);
        check("reset_row_valid", row_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        idle(6);

        mark();
        send_bits(16'hB2, 8); idle(20);
        check("b2_row", row_data, 8'hB2);
        check("b2_valid_cnt", n_valid - v0, 1);
        check("b2_err_cnt", n_err - e0, 0);
        check("b2_ovr_cnt", n_ovr - o0, 0);

        mark();
        send_bits(16'b10110, 5); idle(20);
        check("short_row_kept", row_data, 8'hB2);
        check("short_err_cnt", n_err - e0, 1);
        check("short_valid_cnt", n_valid - v0, 0);

        mark();
        send_bits(16'b0011_1100_10, 10); idle(20);
        check("long_row", row_data, 8'h3C);
        check("long_valid_cnt", n_valid - v0, 1);
        check("long_ovr_cnt", n_ovr - o0, 2);
        send_bits(16'hC3, 8); idle(20);
        check("after_long_row", row_data, 8'hC3);

        mark();
        send_bits(16'hF, 4); idle(1);
        reset = 1'b1; idle(3);
        reset = 1'b0; idle(6);
        send_bits(16'h5A, 8); idle(20);
        check("midreset_row", row_data, 8'h5A);
        check("midreset_err_cnt", n_err - e0, 0);
        check("midreset_valid_cnt", n_valid - v0, 1);

        reset = 1'b1; sclk = 1'b1; idle(3);
        mark();
        reset = 1'b0; idle(4);
        sclk = 1'b0; idle(4);
        send_bits(16'h81, 8); idle(20);
        check("sclk_high_row", row_data, 8'h81);
        check("sclk_high_valid_cnt", n_valid - v0, 1);
        check("sclk_high_ovr_cnt", n_ovr - o0, 0);

        mark();
        send_bits(16'hFF, 8); idle(3);
        check("b2b_first_row", row_data, 8'hFF);
        send_bits(16'h00, 8); idle(20);
        check("b2b_second_row", row_data, 8'h00);
        check("b2b_valid_cnt", n_valid - v0, 2);
        check("b2b_ovr_cnt", n_ovr - o0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_row_rx.md
SHIFT_ROW_RX -- requirements
Module: shift_row_rx

Interface
REQ-001 Parameter WIDTH, default 150: data bits per row (one row = one burst of sclk rising edges).
REQ-002 Parameter WIDTH_BITS, default 8: bit-counter sizing; the counter SHALL be WIDTH_BITS+2 bits wide.
REQ-003 Parameter GAP, default 16: number of consecutive clk_in cycles without an sclk rising edge that ends a burst.
REQ-004 Parameter GAP_BITS, default 5: gap counter width; the counter SHALL hold values up to GAP inclusive.
REQ-005 Port clk_in, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port sclk, input, 1: burst shift clock generated from clk_in by the transmitter, which toggles at most every other clk_in cycle; treated as data, never used as a clock.
REQ-008 Port sdata, input, 1: serial data, stable around each sclk rising edge.
REQ-009 Port row_data, output, WIDTH: last complete row; the first bit received SHALL land in row_data[WIDTH-1].
REQ-010 Port row_valid, output, 1: single-cycle pulse marking a new row_data.
REQ-011 Port frame_err, output, 1: single-cycle pulse when a burst ends with fewer than WIDTH bits.
REQ-012 Port overrun, output, 1: single-cycle pulse for each sclk edge that arrives after WIDTH bits, before the gap.

Function
REQ-013 sclk and sdata SHALL each pass through a 2-flop synchronizer; a rising edge is a synchronized sclk at 1 with its previous sample at 0.
REQ-014 On each detected edge in SHIFT or IDLE, the synchronized sdata SHALL be shifted into an internal shift register, MSB-first, and the bit count incremented.
REQ-015 Latency: a bit is captured on the 3rd clk_in edge after the sclk pin rises.
REQ-016 FSM states: IDLE, SHIFT, DONE, WAIT_GAP.
REQ-017 IDLE: on an edge, capture bit 1, set count=1, clear the gap counter, and go to SHIFT; otherwise stay in IDLE.
REQ-018 SHIFT: on an edge, capture and increment, and clear the gap counter; when count reaches WIDTH, go to DONE.
REQ-019 SHIFT: on a cycle with no edge, increment the gap counter; at GAP, pulse frame_err, clear count, go to IDLE, and leave row_data unchanged.
REQ-020 DONE (one cycle): copy the shift register to row_data, pulse row_valid, go to WAIT_GAP.
REQ-021 WAIT_GAP: an edge SHALL pulse overrun, discard the bit, and clear the gap counter; GAP edge-free cycles SHALL clear count and return the FSM to IDLE.
REQ-022 row_data SHALL hold stable between row_valid pulses; row_valid, frame_err and overrun are never asserted in the same cycle.
REQ-023 Wrap-around: bit count and gap counter SHALL saturate and never wrap; GAP=1 is legal.
REQ-024 WIDTH=1: IDLE SHALL move directly to DONE on the first edge.

Reset
REQ-025 While reset is high: FSM=IDLE, count=0, gap counter=0, shift register=0, row_data=0, row_valid=0, frame_err=0, overrun=0, synchronizer and previous-sample flops=0.
REQ-026 Edge detection SHALL be inhibited for the first 3 clk_in cycles after reset deasserts, so a high sclk at release is not treated as an edge.
REQ-027 Reset asserted mid-burst SHALL discard the partial row without a frame_err pulse.

Structure
REQ-028 FSM state encodings and the synchronizer depth (2) SHALL be defined as constants in a shared package together with the clock generator's state constants.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, sync_edge_det (inputs clk_in, reset, sig; outputs sig_sync, rise), instantiated twice.

Verification (bench parameters: WIDTH=8, GAP=6; sclk toggles every 2 clk_in cycles)
REQ-030 Burst of 8 edges carrying 8'b1011_0010 followed by a 20-cycle gap -> one row_valid; row_data=8'hB2; no frame_err or overrun.
REQ-031 Burst of 5 edges followed by a gap -> frame_err pulses on the 6th edge-free cycle; row_data keeps its previous value; FSM returns to IDLE.
REQ-032 Burst of 10 edges -> row_valid with the first 8 bits, then 2 overrun pulses; the next valid burst decodes correctly.
REQ-033 Reset pulsed after the 4th edge of a burst, then a full burst of 8'h5A -> no frame_err; row_data=8'h5A.
REQ-034 sclk held high through reset release, then a valid burst -> no spurious capture; the first bit decodes into row_data[7].
REQ-035 Two back-to-back bursts (8'hFF, 8'h00) separated by exactly GAP idle cycles -> two row_valid pulses with the correct data each.
